// File: rtl/barrel_shifter_pipe_if.sv
// Beat handshake bundle for barrel_shifter_pipe: the upstream valid/ready with
// its operand fields, and the downstream valid/ready with the result and tag.
interface barrel_shifter_pipe_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4
);
   localparam int SHIFT_W = $clog2(DATA_WIDTH);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] data_in;
   logic [SHIFT_W-1:0]    shift_number_in;
   logic [1:0]            mode_in;
   logic [TAG_WIDTH-1:0]  tag_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] data_after_shift_out;
   logic [TAG_WIDTH-1:0]  tag_out;

   modport master (
      output in_valid, data_in, shift_number_in, mode_in, tag_in, out_ready,
      input  in_ready, out_valid, data_after_shift_out, tag_out
   );

   modport slave (
      input  in_valid, data_in, shift_number_in, mode_in, tag_in, out_ready,
      output in_ready, out_valid, data_after_shift_out, tag_out
   );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined log barrel shifter (ROTL/ROTR/SHL/SHR) with a register stage every
// REG_EVERY levels, tag sideband and valid/ready flow control with bubble collapse.
module barrel_shifter_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_EVERY  = 2,
   parameter int TAG_WIDTH  = 4
) (
   input logic                  clk_in,
   input logic                  reset_in,
   barrel_shifter_pipe_if.slave bus
);
   localparam int SHIFT_W = $clog2(DATA_WIDTH);
   localparam int LEVELS  = SHIFT_W;
   localparam int STAGES  = (LEVELS + REG_EVERY - 1) / REG_EVERY;

   localparam logic [1:0] MODE_ROTL = 2'b00;
   localparam logic [1:0] MODE_ROTR = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;

   // One log-shifter level: move the operand by 2^k in the direction the mode asks.
   function automatic logic [DATA_WIDTH-1:0] shift_level(
      input logic [DATA_WIDTH-1:0] d,
      input logic [1:0]            mode,
      input int                    k
   );
      int off;
      off = 1 << k;
      case (mode)
         MODE_ROTL: shift_level = (d << off) | (d >> (DATA_WIDTH - off));
         MODE_ROTR: shift_level = (d >> off) | (d << (DATA_WIDTH - off));
         MODE_SHL:  shift_level = d << off;
         default:   shift_level = d >> off;
      endcase
   endfunction

   logic [STAGES-1:0]     r_vld;
   logic [DATA_WIDTH-1:0] r_data [STAGES];
   logic [SHIFT_W-1:0]    r_amt  [STAGES];
   logic [1:0]            r_mode [STAGES];
   logic [TAG_WIDTH-1:0]  r_tag  [STAGES];

   logic [STAGES-1:0]     w_src_vld;
   logic [DATA_WIDTH-1:0] w_src_data [STAGES];
   logic [SHIFT_W-1:0]    w_src_amt  [STAGES];
   logic [1:0]            w_src_mode [STAGES];
   logic [TAG_WIDTH-1:0]  w_src_tag  [STAGES];
   logic [DATA_WIDTH-1:0] w_shifted  [STAGES];
   logic [STAGES-1:0]     w_adv;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int LO = s * REG_EVERY;
      localparam int HI = ((s + 1) * REG_EVERY < LEVELS) ? (s + 1) * REG_EVERY : LEVELS;

      logic [DATA_WIDTH-1:0] w_acc;

      if (s == 0) begin : g_head
         assign w_src_vld[0]  = bus.in_valid;
         assign w_src_data[0] = bus.data_in;
         assign w_src_amt[0]  = bus.shift_number_in;
         assign w_src_mode[0] = bus.mode_in;
         assign w_src_tag[0]  = bus.tag_in;
      end else begin : g_body
         assign w_src_vld[s]  = r_vld[s-1];
         assign w_src_data[s] = r_data[s-1];
         assign w_src_amt[s]  = r_amt[s-1];
         assign w_src_mode[s] = r_mode[s-1];
         assign w_src_tag[s]  = r_tag[s-1];
      end

      always_comb begin
         w_acc = w_src_data[s];
         for (int k = LO; k < HI; k++) begin
            if (w_src_amt[s][k]) w_acc = shift_level(w_acc, w_src_mode[s], k);
         end
      end

      assign w_shifted[s] = w_acc;
   end

   // A stage may move whenever the sink takes a beat or any stage at or below it holds a bubble.
   always_comb begin
      w_adv = '0;
      for (int s = 0; s < STAGES; s++) begin
         w_adv[s] = bus.out_ready;
         for (int j = s; j < STAGES; j++) begin
            if (!r_vld[j]) w_adv[s] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_vld <= '0;
         for (int s = 0; s < STAGES; s++) begin
            r_data[s] <= '0;
            r_amt[s]  <= '0;
            r_mode[s] <= '0;
            r_tag[s]  <= '0;
         end
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (w_adv[s]) begin
               r_vld[s]  <= w_src_vld[s];
               r_data[s] <= w_shifted[s];
               r_amt[s]  <= w_src_amt[s];
               r_mode[s] <= w_src_mode[s];
               r_tag[s]  <= w_src_tag[s];
            end
         end
      end
   end

   assign bus.in_ready             = w_adv[0] & ~reset_in;
   assign bus.out_valid            = r_vld[STAGES-1];
   assign bus.data_after_shift_out = r_data[STAGES-1];
   assign bus.tag_out              = r_tag[STAGES-1];
endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe: bit-level reference model with a scoreboard,
// directed literal cases, backpressure, random traffic, mid-stream reset, width sweep.
module tb_barrel_shifter_pipe;
   localparam int W  = 32;
   localparam int ST = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   barrel_shifter_pipe_if #(.DATA_WIDTH(32), .TAG_WIDTH(4)) bus ();
   barrel_shifter_pipe_if #(.DATA_WIDTH(8),  .TAG_WIDTH(4)) bus8 ();
   barrel_shifter_pipe_if #(.DATA_WIDTH(64), .TAG_WIDTH(4)) bus64 ();

   barrel_shifter_pipe #(.DATA_WIDTH(32), .REG_EVERY(2), .TAG_WIDTH(4)) dut (
      .clk_in(clk), .reset_in(rst), .bus(bus));
   barrel_shifter_pipe #(.DATA_WIDTH(8), .REG_EVERY(1), .TAG_WIDTH(4)) dut8 (
      .clk_in(clk), .reset_in(rst), .bus(bus8));
   barrel_shifter_pipe #(.DATA_WIDTH(64), .REG_EVERY(6), .TAG_WIDTH(4)) dut64 (
      .clk_in(clk), .reset_in(rst), .bus(bus64));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: move individual bits according to the mode's definition.
   function automatic logic [63:0] ref_shift(input logic [63:0] d, input int s,
                                             input logic [1:0] m, input int w);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         case (m)
            2'd0: r[(i + s) % w] = d[i];
            2'd1: r[i] = d[(i + s) % w];
            2'd2: if (i + s < w) r[i + s] = d[i];
            2'd3: if (i >= s) r[i - s] = d[i];
         endcase
      end
      return r;
   endfunction

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  tag;
   } beat_t;

   beat_t       q[$];
   logic [3:0]  emit_log[$];
   int          n_acc = 0;
   beat_t       sb_new;
   beat_t       sb_exp;
   logic [63:0] sb_tmp;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic [3:0]  prev_tag;

   // Scoreboard for the 32-bit instance: every cycle, ahead of the next rising edge.
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         check("in_ready_rule", bus.in_ready, (bus.out_ready || q.size() < ST));
         if (prev_stall) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.data_after_shift_out, prev_data);
            check("hold_tag", bus.tag_out, prev_tag);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_out_valid", bus.out_valid, 0);
            end else begin
               sb_exp = q.pop_front();
               check("sb_data", bus.data_after_shift_out, sb_exp.data);
               check("sb_tag", bus.tag_out, sb_exp.tag);
               emit_log.push_back(bus.tag_out);
            end
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.data_after_shift_out;
         prev_tag   = bus.tag_out;
         if (bus.in_valid && bus.in_ready) begin
            sb_tmp = ref_shift(64'(bus.data_in), int'(bus.shift_number_in), bus.mode_in, W);
            sb_new.data = sb_tmp[31:0];
            sb_new.tag  = bus.tag_in;
            q.push_back(sb_new);
            n_acc++;
         end
      end
   end

   task automatic single_beat(input logic [31:0] d, input logic [4:0] s, input logic [1:0] m,
                              input logic [3:0] t, input logic [31:0] exp, input string nm);
      int lat;
      int guard;
      bus.data_in         = d;
      bus.shift_number_in = s;
      bus.mode_in         = m;
      bus.tag_in          = t;
      bus.in_valid        = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({nm, "_accept"}, bus.in_ready, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus.out_valid && lat < 20) begin
         lat++;
         @(negedge clk);
      end
      check({nm, "_data"}, bus.data_after_shift_out, exp);
      check({nm, "_tag"}, bus.tag_out, t);
      check({nm, "_latency"}, lat, ST);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [31:0] d;
      logic [4:0]  s;
      logic [1:0]  m;
      logic [31:0] e;
   } vec_t;

   vec_t vecs[11] = '{
      '{32'h80000001, 5'd1,  2'd0, 32'h00000003},
      '{32'h00000001, 5'd4,  2'd1, 32'h10000000},
      '{32'hFFFFFFFF, 5'd31, 2'd2, 32'h80000000},
      '{32'h80000000, 5'd31, 2'd3, 32'h00000001},
      '{32'hDEADBEEF, 5'd0,  2'd0, 32'hDEADBEEF},
      '{32'hDEADBEEF, 5'd0,  2'd1, 32'hDEADBEEF},
      '{32'hDEADBEEF, 5'd0,  2'd2, 32'hDEADBEEF},
      '{32'hDEADBEEF, 5'd0,  2'd3, 32'hDEADBEEF},
      '{32'h12345678, 5'd12, 2'd0, 32'h45678123},
      '{32'h12345678, 5'd9,  2'd0, 32'h68ACF024},
      '{32'h12345678, 5'd17, 2'd0, 32'hACF02468}
   };

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int cyc;
      int lat;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.data_in = '0;
      bus.shift_number_in = '0; bus.mode_in = '0; bus.tag_in = '0;
      bus8.in_valid = 1'b0; bus8.out_ready = 1'b1; bus8.data_in = '0;
      bus8.shift_number_in = '0; bus8.mode_in = '0; bus8.tag_in = '0;
      bus64.in_valid = 1'b0; bus64.out_ready = 1'b1; bus64.data_in = '0;
      bus64.shift_number_in = '0; bus64.mode_in = '0; bus64.tag_in = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_data", bus.data_after_shift_out, 0);
      check("rst_tag", bus.tag_out, 0);
      check("rst_in_ready", bus.in_ready, 0);
      rst = 1'b0;
      #1 check("release_in_ready", bus.in_ready, 1);

      check("model_rotl12", ref_shift(64'h12345678, 12, 2'd0, 32), 64'h45678123);
      check("model_rotr4", ref_shift(64'h1, 4, 2'd1, 32), 64'h10000000);
      check("model_shr31", ref_shift(64'h80000000, 31, 2'd3, 32), 64'h1);
      check("model_rotr64", ref_shift(64'h1, 1, 2'd1, 64), 64'h8000000000000000);

      @(posedge clk);
      #1;
      for (int i = 0; i < 11; i++)
         single_beat(vecs[i].d, vecs[i].s, vecs[i].m, 4'(i), vecs[i].e, $sformatf("vec%0d", i));

      // Backpressure: three beats fill the pipe, the fourth waits.
      emit_log.delete();
      base = n_acc;
      bus.out_ready = 1'b0;
      for (int t = 0; t < 3; t++) begin
         bus.in_valid = 1'b1; bus.tag_in = 4'(t); bus.data_in = $urandom;
         bus.shift_number_in = 5'($urandom_range(0, 31)); bus.mode_in = 2'($urandom_range(0, 3));
         @(negedge clk);
         check("bp_accept", bus.in_ready, 1);
         @(posedge clk);
         #1;
      end
      bus.tag_in = 4'd3; bus.data_in = $urandom;
      repeat (3) begin
         @(negedge clk);
         check("bp_full_in_ready", bus.in_ready, 0);
         check("bp_full_out_valid", bus.out_valid, 1);
      end
      check("bp_accepted", n_acc - base, 3);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_enter_while_leave", bus.in_ready, 1);
      @(posedge clk);
      #1 bus.tag_in = 4'd4; bus.data_in = $urandom;
      @(negedge clk);
      check("bp_accept4", bus.in_ready, 1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("bp_emit_count", emit_log.size(), 5);
      for (int i = 0; i < 5 && i < emit_log.size(); i++)
         check($sformatf("bp_order%0d", i), emit_log[i], i);

      // Random traffic with bubbles and stalls.
      base = n_acc;
      cyc  = 0;
      while (n_acc - base < 2000 && cyc < 30000) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.data_in = $urandom;
         bus.shift_number_in = 5'($urandom_range(0, 31));
         bus.mode_in = 2'($urandom_range(0, 3));
         bus.tag_in = 4'($urandom_range(0, 15));
         @(posedge clk);
         #1 cyc++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      check("rand_accepted", n_acc - base, 2000);
      repeat (10) @(posedge clk);
      #1 check("rand_drained", q.size(), 0);

      // Reset with a full pipe: in-flight beats must vanish.
      bus.out_ready = 1'b0;
      for (int t = 10; t < 13; t++) begin
         bus.in_valid = 1'b1; bus.tag_in = 4'(t); bus.data_in = $urandom;
         bus.shift_number_in = 5'($urandom_range(0, 31)); bus.mode_in = 2'($urandom_range(0, 3));
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_data", bus.data_after_shift_out, 0);
      check("midrst_in_ready", bus.in_ready, 0);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("midrst_no_ghost", bus.out_valid, 0);
      end
      @(posedge clk);
      #1;
      single_beat(32'hA5A5_0F0F, 5'd8, 2'd0, 4'hC, 32'hA50F_0FA5, "post_rst");

      // Width sweep: 8-bit with a register per level, 64-bit with a single stage.
      bus8.data_in = 8'h81; bus8.shift_number_in = 3'd1; bus8.mode_in = 2'd0;
      bus8.tag_in = 4'h7; bus8.in_valid = 1'b1;
      @(negedge clk);
      check("w8_accept", bus8.in_ready, 1);
      @(posedge clk);
      #1 bus8.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus8.out_valid && lat < 20) begin
         lat++;
         @(negedge clk);
      end
      check("w8_data", bus8.data_after_shift_out, 8'h03);
      check("w8_tag", bus8.tag_out, 4'h7);
      check("w8_latency", lat, 3);
      @(posedge clk);
      #1;

      bus64.data_in = 64'h1; bus64.shift_number_in = 6'd1; bus64.mode_in = 2'd1;
      bus64.tag_in = 4'h9; bus64.in_valid = 1'b1;
      @(negedge clk);
      check("w64_accept", bus64.in_ready, 1);
      @(posedge clk);
      #1 bus64.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus64.out_valid && lat < 20) begin
         lat++;
         @(negedge clk);
      end
      check("w64_data", bus64.data_after_shift_out, 64'h8000000000000000);
      check("w64_tag", bus64.tag_out, 4'h9);
      check("w64_latency", lat, 1);
      @(posedge clk);
      #1 check("final_sb_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
